// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one 1-bit subtract cell stepped LSB-first,
// sequenced by an IDLE/RUN/DONE FSM with a start/done requester handshake.
module serial_subtractor_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             bin_q, bin_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bout_q, bout_d;

   // Shared 1-bit subtract cell: two half subtractors plus borrow OR
   logic hs1_d_c, hs1_b_c, hs2_b_c, cell_d_c, cell_bout_c;
   always_comb begin
      hs1_d_c     = a_sh_q[0] ^ b_sh_q[0];
      hs1_b_c     = ~a_sh_q[0] & b_sh_q[0];
      cell_d_c    = hs1_d_c ^ bin_q;
      hs2_b_c     = ~hs1_d_c & bin_q;
      cell_bout_c = hs1_b_c | hs2_b_c;
   end

   // State and datapath registers; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         diff_q  <= '0;
         idx_q   <= '0;
         bin_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         diff_q  <= diff_d;
         idx_q   <= idx_d;
         bin_q   <= bin_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bout_q  <= bout_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      diff_d  = diff_q;
      idx_d   = idx_q;
      bin_d   = bin_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bout_d  = bout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               bin_d   = 1'b0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Result bit enters at the MSB; after WIDTH steps it is aligned
            diff_d = (diff_q >> 1) | (WIDTH'(cell_d_c) << (WIDTH - 1));
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            bin_d  = cell_bout_c;
            if (idx_q == LAST_IDX) begin
               bout_d  = cell_bout_c;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule
